// File: rtl/point_frame_tx_pkg.sv
// point_frame_tx_pkg
// Shared constants and types for the point-frame UART transmitter:
//   DEFAULT_NUM_POINTS  default number of (x,y) pairs per frame
//   DEFAULT_SYNC0/1     default frame sync bytes
//   FRAME_LEN           frame length in bytes for the default point count
//   state_e             transmitter FSM states
package point_frame_tx_pkg;

    localparam int unsigned DEFAULT_NUM_POINTS = 12;
    localparam logic [7:0]  DEFAULT_SYNC0      = 8'hAA;
    localparam logic [7:0]  DEFAULT_SYNC1      = 8'h55;

    // SYNC0, SYNC1, SEQ, CNT, 8 bytes per point, CSUM
    function automatic int unsigned frame_len(input int unsigned num_points);
        return 4 + 8 * num_points + 1;
    endfunction

    localparam int unsigned FRAME_LEN = 4 + 8 * DEFAULT_NUM_POINTS + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSyncA,
        StSyncB,
        StSeq,
        StCnt,
        StPayload,
        StCsum
    } state_e;

endpackage

// File: rtl/point_frame_tx.sv
// point_frame_tx
// Serialises one set of (x,y) Q16.16 points into a byte frame for a UART TX FIFO:
//   SYNC0 SYNC1 SEQ CNT {x[i] LE32, y[i] LE32}*NUM_POINTS CSUM
// CSUM is the XOR of SEQ through the last payload byte.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   result_valid      one-cycle pulse; result_x/result_y are captured when idle
//   result_x/result_y signed Q16.16 coordinates, NUM_POINTS entries each
//   fifo_full         TX FIFO full; no write is issued while high
//   dout, wr_en       byte and write strobe to the FIFO (dout is 0 when not writing)
//   busy              a frame is in progress
//   frame_done        one-cycle pulse on the checksum write
//   drop_count        saturating count of result_valid pulses ignored while busy
module point_frame_tx
    import point_frame_tx_pkg::*;
#(
    parameter int unsigned NUM_POINTS = DEFAULT_NUM_POINTS,
    parameter logic [7:0]  SYNC0      = DEFAULT_SYNC0,
    parameter logic [7:0]  SYNC1      = DEFAULT_SYNC1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               result_valid,
    input  logic signed [31:0] result_x [NUM_POINTS],
    input  logic signed [31:0] result_y [NUM_POINTS],
    input  logic               fifo_full,
    output logic [7:0]         dout,
    output logic               wr_en,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         drop_count
);

    localparam int unsigned PAYLOAD_LEN = 8 * NUM_POINTS;
    localparam int unsigned CNT_W       = $clog2(PAYLOAD_LEN);
    localparam int unsigned PT_W        = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [7:0]       CNT_BYTE = 8'(NUM_POINTS);

    state_e             state_q, state_d;
    logic [7:0]         seq_q, seq_d;
    logic [7:0]         csum_q, csum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         drop_q, drop_d;
    logic signed [31:0] x_q [NUM_POINTS];
    logic signed [31:0] y_q [NUM_POINTS];

    logic               accept;
    logic [PT_W-1:0]    pt_idx;
    logic [31:0]        word;
    logic [7:0]         payload_byte;
    logic [7:0]         byte_val;

    assign accept = (state_q == StIdle) && result_valid;

    // Payload counter: bits [2] pick x/y, bits [1:0] pick the byte (LSB first),
    // upper bits are the point index.
    assign pt_idx = PT_W'(cnt_q >> 3);
    assign word   = cnt_q[2] ? y_q[pt_idx] : x_q[pt_idx];

    always_comb begin
        payload_byte = 8'h00;
        unique case (cnt_q[1:0])
            2'd0: payload_byte = word[7:0];
            2'd1: payload_byte = word[15:8];
            2'd2: payload_byte = word[23:16];
            2'd3: payload_byte = word[31:24];
            default: payload_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        byte_val   = 8'h00;
        frame_done = 1'b0;
        // Gated by rst so an abort stops writes in the reset cycle itself.
        wr_en      = (state_q != StIdle) && !fifo_full && !rst;

        unique case (state_q)
            StIdle: begin
                if (result_valid) begin
                    state_d = StSyncA;
                    csum_d  = 8'h00;
                    cnt_d   = '0;
                end
            end
            StSyncA: begin
                byte_val = SYNC0;
                if (wr_en) state_d = StSyncB;
            end
            StSyncB: begin
                byte_val = SYNC1;
                if (wr_en) state_d = StSeq;
            end
            StSeq: begin
                byte_val = seq_q;
                if (wr_en) begin
                    csum_d  = csum_q ^ seq_q;
                    state_d = StCnt;
                end
            end
            StCnt: begin
                byte_val = CNT_BYTE;
                if (wr_en) begin
                    csum_d  = csum_q ^ CNT_BYTE;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                byte_val = payload_byte;
                if (wr_en) begin
                    csum_d = csum_q ^ payload_byte;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StCsum;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StCsum: begin
                byte_val = csum_q;
                if (wr_en) begin
                    frame_done = 1'b1;
                    seq_d      = seq_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (result_valid && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign dout       = wr_en ? byte_val : 8'h00;
    assign busy       = (state_q != StIdle);
    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            seq_q   <= 8'h00;
            csum_q  <= 8'h00;
            cnt_q   <= '0;
            drop_q  <= 8'h00;
            for (int i = 0; i < int'(NUM_POINTS); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            // Point data is frozen for the whole frame; only an idle accept loads it.
            if (accept) begin
                x_q <= result_x;
                y_q <= result_y;
            end
        end
    end

endmodule
